gray_conv_arbiter: RTL and testbench

//  - Shares one combinational gray_to_binary converter among NUM_REQ requesters, e.g. pointer/counter

---
 rtl/gray_conv_pkg.sv | 37 +++
 rtl/gray_to_binary.sv | 18 +
 rtl/gray_conv_arbiter.sv | 95 +++++++++
 tb/tb_gray_conv_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_conv_pkg.sv
// Shared types and helpers for the Gray-decode arbiter slice.
package gray_conv_pkg;

  localparam int CNT_W   = 16;
  localparam int MAX_REQ = 32;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } pick_t;

  // Width of a requester index; a single requester still gets one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round-robin search: first set bit of vld at or after ptr, wrapping at n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] vld,
                                    input int unsigned        ptr,
                                    input int unsigned        n);
    pick_t       r;
    int unsigned idx;
    r = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (!r.found && vld[idx[4:0]]) begin
          r.found = 1'b1;
          r.idx   = idx[4:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary decoder.
module gray_to_binary #(
  parameter int N = 4
) (
  input  logic [N-1:0] gray_i,
  output logic [N-1:0] bin_o
);

  // Each binary bit is the running XOR of the Gray bits from the MSB down.
  always_comb begin
    bin_o        = '0;
    bin_o[N-1]   = gray_i[N-1];
    for (int unsigned k = 1; k < N; k++) begin
      bin_o[N-1-k] = bin_o[N-k] ^ gray_i[N-1-k];
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin sharing of one Gray decoder among NUM_REQ requesters,
// with a single registered, ID-tagged result stage.
module gray_conv_arbiter
  import gray_conv_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int W       = 4,
  localparam int IDW     = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [W-1:0]       req_gray [NUM_REQ],
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_binary,
  output logic [IDW-1:0]     out_id,
  output logic [CNT_W-1:0]   out_count
);

  logic [IDW-1:0]   ptr_q,        ptr_d;
  logic             out_valid_q,  out_valid_d;
  logic [W-1:0]     out_binary_q, out_binary_d;
  logic [IDW-1:0]   out_id_q,     out_id_d;
  logic [CNT_W-1:0] out_count_q,  out_count_d;

  pick_t          pick;
  logic [IDW-1:0] grant;
  logic           can_accept;
  logic           accept;
  logic           drain;
  logic [W-1:0]   gray_sel;
  logic [W-1:0]   bin_sel;
  logic           pick_unused;

  assign pick_unused = &{1'b0, pick.idx};

  gray_to_binary #(.N(W)) u_g2b (
    .gray_i (gray_sel),
    .bin_o  (bin_sel)
  );

  // Arbitration, handshake decode and next-state selection.
  always_comb begin
    pick       = rr_pick(MAX_REQ'(req_valid), 32'(ptr_q), 32'(NUM_REQ));
    grant      = pick.idx[IDW-1:0];
    can_accept = !out_valid_q || out_ready;
    // Gated by rst_n so nothing is offered as accepted in a reset cycle.
    accept     = rst_n && pick.found && can_accept;
    drain      = out_valid_q && out_ready;
    gray_sel   = req_gray[grant];

    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;

    ptr_d        = ptr_q;
    out_valid_d  = out_valid_q;
    out_binary_d = out_binary_q;
    out_id_d     = out_id_q;
    out_count_d  = out_count_q + CNT_W'(drain);

    if (accept) begin
      out_valid_d  = 1'b1;
      out_binary_d = bin_sel;
      out_id_d     = grant;
      ptr_d        = (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    end else if (drain) begin
      out_valid_d  = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      out_valid_q  <= 1'b0;
      out_binary_q <= '0;
      out_id_q     <= '0;
      out_count_q  <= '0;
    end else begin
      ptr_q        <= ptr_d;
      out_valid_q  <= out_valid_d;
      out_binary_q <= out_binary_d;
      out_id_q     <= out_id_d;
      out_count_q  <= out_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_binary = out_binary_q;
  assign out_id     = out_id_q;
  assign out_count  = out_count_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter (NUM_REQ=4, W=4).
module tb_gray_conv_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [W-1:0]  req_gray [N];
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_binary;
  logic [1:0]    out_id;
  logic [15:0]   out_count;

  int n_run  = 0;
  int n_fail = 0;

  // Reference model state
  int          m_ptr;
  logic        m_valid;
  logic [W-1:0] m_bin;
  int          m_id;
  logic [15:0] m_count;

  always #5 clk = ~clk;

  gray_conv_arbiter #(.NUM_REQ(N), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_gray   (req_gray),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_binary (out_binary),
    .out_id     (out_id),
    .out_count  (out_count)
  );

  // Gray decode as XOR of all right shifts of the word.
  function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int s = 1; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  // Index granted this cycle, or -1 when nothing is offered.
  function automatic int ref_grant();
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] ref_ready();
    int g;
    g = ref_grant();
    if (!rst_n || g < 0 || (m_valid && !out_ready)) return '0;
    return N'(1) << g;
  endfunction

  function automatic void ref_update();
    int   g;
    logic acc;
    if (!rst_n) begin
      m_ptr = 0; m_valid = 1'b0; m_bin = '0; m_id = 0; m_count = '0;
      return;
    end
    g   = ref_grant();
    acc = (g >= 0) && (!m_valid || out_ready);
    if (m_valid && out_ready) m_count = m_count + 16'd1;
    if (acc) begin
      m_bin   = ref_g2b(req_gray[g]);
      m_id    = g;
      m_valid = 1'b1;
      m_ptr   = (g + 1) % N;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  endfunction

  // One clock: sample req_ready mid-cycle, advance model at the edge.
  task automatic tick(output logic [N-1:0] exp_rdy, output logic [N-1:0] got_rdy);
    @(negedge clk);
    got_rdy = req_ready;
    exp_rdy = ref_ready();
    @(posedge clk);
    ref_update();
    #1;
  endtask

  task automatic test_reset();
    logic [N-1:0] e, g;
    rst_n = 1'b0; req_valid = '1; out_ready = 1'b1;
    for (int i = 0; i < N; i++) req_gray[i] = W'(i);
    for (int c = 0; c < 2; c++) begin
      tick(e, g);
      n_run++;
      if (g !== 4'b0000) begin
        n_fail++; $display("FAIL reset_ready got=%b exp=0000", g);
      end
    end
    n_run++;
    if (out_valid !== 1'b0 || out_count !== 16'd0 || out_binary !== 4'd0 || out_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state got v=%b cnt=%0d bin=%b id=%0d exp v=0 cnt=0 bin=0000 id=0",
               out_valid, out_count, out_binary, out_id);
    end
  endtask

  task automatic test_single();
    logic [N-1:0] e, g;
    rst_n = 1'b1; req_valid = 4'b0001; req_gray[0] = 4'b1101; out_ready = 1'b1;
    tick(e, g);
    n_run++;
    if (g !== 4'b0001) begin n_fail++; $display("FAIL single_ready got=%b exp=0001", g); end
    n_run++;
    if (out_valid !== 1'b1 || out_binary !== 4'b1001 || out_id !== 2'd0) begin
      n_fail++;
      $display("FAIL single_out got v=%b bin=%b id=%0d exp v=1 bin=1001 id=0", out_valid, out_binary, out_id);
    end
    req_valid = '0;
    tick(e, g);
    n_run++;
    if (out_valid !== 1'b0 || out_count !== 16'd1 || out_binary !== 4'b1001) begin
      n_fail++;
      $display("FAIL single_drain got v=%b cnt=%0d bin=%b exp v=0 cnt=1 bin=1001", out_valid, out_count, out_binary);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] e, g;
    rst_n = 1'b0; tick(e, g);
    rst_n = 1'b1; req_valid = '1; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < N; i++) req_gray[i] = W'($urandom_range(0, 15));
      tick(e, g);
      n_run++;
      if (g !== (N'(1) << (k % N))) begin
        n_fail++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, g, N'(1) << (k % N));
      end
      n_run++;
      if (out_id !== 2'(k % N) || out_binary !== m_bin) begin
        n_fail++; $display("FAIL rr_out[%0d] got id=%0d bin=%b exp id=%0d bin=%b", k, out_id, out_binary, k % N, m_bin);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] e, g;
    req_valid = 4'b0100; req_gray[2] = 4'b1000; out_ready = 1'b1;
    tick(e, g);
    n_run++;
    if (g !== 4'b0100) begin n_fail++; $display("FAIL bp_accept got=%b exp=0100", g); end
    out_ready = 1'b0; req_valid = '1;
    for (int c = 0; c < 3; c++) begin
      tick(e, g);
      n_run++;
      if (g !== 4'b0000 || out_valid !== 1'b1 || out_binary !== 4'b1111 || out_id !== 2'd2) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got rdy=%b v=%b bin=%b id=%0d exp rdy=0000 v=1 bin=1111 id=2",
                 c, g, out_valid, out_binary, out_id);
      end
    end
    out_ready = 1'b1;
    tick(e, g);
    n_run++;
    if (g !== 4'b1000) begin n_fail++; $display("FAIL bp_ptr_kept got=%b exp=1000", g); end
  endtask

  task automatic test_drain_accept();
    logic [N-1:0] e, g;
    logic [15:0]  cnt_before;
    cnt_before = m_count;
    req_valid = 4'b0100; req_gray[2] = 4'b0110; out_ready = 1'b1;
    tick(e, g);
    n_run++;
    if (g !== 4'b0100 || out_valid !== 1'b1 || out_binary !== 4'b0100 || out_id !== 2'd2
        || out_count !== cnt_before + 16'd1) begin
      n_fail++;
      $display("FAIL drain_accept got rdy=%b v=%b bin=%b id=%0d cnt=%0d exp rdy=0100 v=1 bin=0100 id=2 cnt=%0d",
               g, out_valid, out_binary, out_id, out_count, cnt_before + 16'd1);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] e, g;
    int           wait_c [N];
    for (int i = 0; i < N; i++) wait_c[i] = 0;
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) req_gray[i] = W'($urandom_range(0, 15));
      tick(e, g);
      n_run++;
      if (g !== e) begin n_fail++; $display("FAIL rand_ready[%0d] got=%b exp=%b", c, g, e); end
      n_run++;
      if (out_valid !== m_valid || out_binary !== m_bin || out_id !== 2'(m_id) || out_count !== m_count) begin
        n_fail++;
        $display("FAIL rand_out[%0d] got v=%b bin=%b id=%0d cnt=%0d exp v=%b bin=%b id=%0d cnt=%0d",
                 c, out_valid, out_binary, out_id, out_count, m_valid, m_bin, m_id, m_count);
      end
    end
    // Fairness: a requester held valid must be served within N accepted transfers.
    req_valid = '1; out_ready = 1'b1;
    for (int c = 0; c < 3 * N; c++) begin
      tick(e, g);
      for (int i = 0; i < N; i++) wait_c[i] = g[i] ? 0 : wait_c[i] + 1;
    end
    for (int i = 0; i < N; i++) begin
      n_run++;
      if (wait_c[i] >= N) begin n_fail++; $display("FAIL fair[%0d] got wait=%0d exp <%0d", i, wait_c[i], N); end
    end
  endtask

  task automatic test_counter_wrap();
    logic [N-1:0] e, g;
    int           budget;
    req_valid = '1; out_ready = 1'b1;
    budget = 0;
    while (m_count != 16'hFFFF && budget < 70000) begin
      tick(e, g);
      budget++;
    end
    n_run++;
    if (out_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL wrap_preload got=%h exp=ffff", out_count);
    end
    tick(e, g);
    n_run++;
    if (out_count !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_zero got=%h exp=0000", out_count);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) req_gray[i] = '0;
    m_ptr = 0; m_valid = 1'b0; m_bin = '0; m_id = 0; m_count = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_drain_accept();
    test_random();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
